// File: rtl/csi_tx_clk_lane_pkg.sv
// Shared CSI-2 TX definitions: clock-lane state encoding, LP line levels and
// default D-PHY timings in byte-clock cycles (also used by the data-lane controller).
package csi_tx_pkg;

    typedef enum logic [3:0] {
        STOP,
        HS_RQST,
        BRIDGE,
        HS_ZERO,
        HS_PRE,
        HS_CLK,
        HS_POST,
        HS_TRAIL,
        HS_EXIT
    } clk_lane_state_t;

    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;

    localparam int unsigned DEF_CNT_W         = 6;
    localparam int unsigned DEF_T_LPX         = 2;
    localparam int unsigned DEF_T_CLK_PREPARE = 2;
    localparam int unsigned DEF_T_CLK_ZERO    = 12;
    localparam int unsigned DEF_T_CLK_PRE     = 2;
    localparam int unsigned DEF_T_CLK_POST    = 8;
    localparam int unsigned DEF_T_CLK_TRAIL   = 3;
    localparam int unsigned DEF_T_HS_EXIT     = 4;

    // Timer reload for a phase of t cycles; t == 0 behaves as a 1-cycle phase.
    function automatic int unsigned phase_load(input int unsigned t);
        return (t == 32'd0) ? 32'd0 : t - 32'd1;
    endfunction

endpackage

// File: rtl/csi_tx_clk_lane_if.sv
// Handshake between the clock-lane controller and the data-lane sequencers.
interface csi_tx_clk_lane_if;
    logic enable;
    logic hs_req;
    logic data_done;
    logic hs_rdy;
    logic busy;

    modport master (
        output enable, hs_req, data_done,
        input  hs_rdy, busy
    );

    modport slave (
        input  enable, hs_req, data_done,
        output hs_rdy, busy
    );
endinterface

// File: rtl/csi_tx_clk_lane_phase_tmr.sv
// Phase timer: loadable down-counter that stops at zero; done is high while the count is zero.
module csi_tx_phase_tmr #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             byte_clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge byte_clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/csi_tx_clk_lane.sv
// CSI-2 TX clock-lane controller: LP-11 -> HS clocking -> LP-11 sequencing for the clock-lane IOB.
// Define CSI_TX_CLK_CONTINUOUS_EN for continuous-clock mode (HS_CLK left only on enable low or reset).
module csi_tx_clk_lane
    import csi_tx_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned T_LPX         = DEF_T_LPX,
    parameter int unsigned T_CLK_PREPARE = DEF_T_CLK_PREPARE,
    parameter int unsigned T_CLK_ZERO    = DEF_T_CLK_ZERO,
    parameter int unsigned T_CLK_PRE     = DEF_T_CLK_PRE,
    parameter int unsigned T_CLK_POST    = DEF_T_CLK_POST,
    parameter int unsigned T_CLK_TRAIL   = DEF_T_CLK_TRAIL,
    parameter int unsigned T_HS_EXIT     = DEF_T_HS_EXIT
) (
    input  logic               byte_clock,
    input  logic               reset,
    csi_tx_clk_lane_if.slave   ctl,
    output logic [1:0]         lp_out,
    output logic               hs_oe,
    output logic               hs_clk_en
);

    clk_lane_state_t  state_q, state_d;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic [1:0]       lp_d;
    logic             oe_d, clk_en_d, rdy_d, busy_d;
    logic             hs_rdy_q, busy_q;

    csi_tx_phase_tmr #(.CNT_W(CNT_W)) u_tmr (
        .byte_clock (byte_clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .done       (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP:     if (ctl.enable && ctl.hs_req) state_d = HS_RQST;
            HS_RQST:  if (!ctl.enable) state_d = STOP;     else if (tmr_done) state_d = BRIDGE;
            BRIDGE:   if (!ctl.enable) state_d = STOP;     else if (tmr_done) state_d = HS_ZERO;
            HS_ZERO:  if (!ctl.enable) state_d = HS_TRAIL; else if (tmr_done) state_d = HS_PRE;
            HS_PRE:   if (!ctl.enable) state_d = HS_TRAIL; else if (tmr_done) state_d = HS_CLK;
`ifdef CSI_TX_CLK_CONTINUOUS_EN
            HS_CLK:   if (!ctl.enable) state_d = HS_TRAIL;
`else
            HS_CLK:   if (!ctl.enable) state_d = HS_TRAIL; else if (ctl.data_done) state_d = HS_POST;
`endif
            HS_POST:  if (tmr_done) state_d = HS_TRAIL;
            HS_TRAIL: if (tmr_done) state_d = HS_EXIT;
            HS_EXIT:  if (tmr_done) state_d = STOP;
            default:  state_d = STOP;
        endcase
    end

    // Timer is reloaded on every state entry with the length of the phase being entered.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            HS_RQST:  tmr_val = CNT_W'(phase_load(T_LPX));
            BRIDGE:   tmr_val = CNT_W'(phase_load(T_CLK_PREPARE));
            HS_ZERO:  tmr_val = CNT_W'(phase_load(T_CLK_ZERO));
            HS_PRE:   tmr_val = CNT_W'(phase_load(T_CLK_PRE));
            HS_POST:  tmr_val = CNT_W'(phase_load(T_CLK_POST));
            HS_TRAIL: tmr_val = CNT_W'(phase_load(T_CLK_TRAIL));
            HS_EXIT:  tmr_val = CNT_W'(phase_load(T_HS_EXIT));
            default:  tmr_val = '0;
        endcase
    end

    always_comb begin
        lp_d     = LP_00;
        oe_d     = 1'b0;
        clk_en_d = 1'b0;
        rdy_d    = 1'b0;
        busy_d   = (state_d != STOP);
        case (state_d)
            STOP, HS_EXIT:     lp_d = LP_11;
            HS_RQST:           lp_d = LP_01;
            HS_ZERO, HS_TRAIL: oe_d = 1'b1;
            HS_PRE, HS_POST: begin
                oe_d     = 1'b1;
                clk_en_d = 1'b1;
            end
            HS_CLK: begin
                oe_d     = 1'b1;
                clk_en_d = 1'b1;
                rdy_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge byte_clock) begin
        if (reset) begin
            state_q   <= STOP;
            lp_out    <= LP_11;
            hs_oe     <= 1'b0;
            hs_clk_en <= 1'b0;
            hs_rdy_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lp_out    <= lp_d;
            hs_oe     <= oe_d;
            hs_clk_en <= clk_en_d;
            hs_rdy_q  <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    assign ctl.hs_rdy = hs_rdy_q;
    assign ctl.busy   = busy_q;

    a_data_done_in_clk: assert property (
        @(posedge byte_clock) disable iff (reset) ctl.data_done |-> (state_q == HS_CLK)
    ) else $warning("csi_tx_clk_lane: protocol error, data_done outside HS_CLK ignored");

endmodule

// File: tb/tb_csi_tx_clk_lane.sv
// Scoreboard bench for csi_tx_clk_lane: directed scenarios push expected output
// transitions (edge number, output vector); a monitor pops one per observed change.
module tb_csi_tx_clk_lane;

    // Output vector {busy, hs_rdy, lp_out[1:0], hs_oe, hs_clk_en} per state
    localparam logic [5:0] V_STOP  = 6'b001100;
    localparam logic [5:0] V_RQST  = 6'b100100;
    localparam logic [5:0] V_BRDG  = 6'b100000;
    localparam logic [5:0] V_ZERO  = 6'b100010;
    localparam logic [5:0] V_PRE   = 6'b100011;
    localparam logic [5:0] V_CLK   = 6'b110011;
    localparam logic [5:0] V_POST  = 6'b100011;
    localparam logic [5:0] V_TRAIL = 6'b100010;
    localparam logic [5:0] V_EXIT  = 6'b101100;

    typedef struct {
        int         edge_n;
        logic [5:0] vec;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] lp_out;
    logic       hs_oe;
    logic       hs_clk_en;
    logic [5:0] vec;
    logic [5:0] prev;
    logic       first = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];

    csi_tx_clk_lane_if ctl ();

    csi_tx_clk_lane dut (
        .byte_clock (clk),
        .reset      (reset),
        .ctl        (ctl),
        .lp_out     (lp_out),
        .hs_oe      (hs_oe),
        .hs_clk_en  (hs_clk_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign vec = {ctl.busy, ctl.hs_rdy, lp_out, hs_oe, hs_clk_en};

    function automatic void push(input int e, input logic [5:0] v, input string t);
        exp_t x;
        x.edge_n = e;
        x.vec    = v;
        x.tag    = t;
        exp_q.push_back(x);
    endfunction

    // Returns at the falling edge just before rising edge k, so inputs set now are sampled at k.
    task automatic at_edge(input int k);
        while (cyc < k - 1) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc >= 3 && (first || vec !== prev)) begin
                first = 1'b0;
                prev  = vec;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: edge %0d got %b, required no change", cyc, vec);
                end else begin
                    e = exp_q.pop_front();
                    if (e.edge_n != cyc || e.vec !== vec)
                    begin
                        errors++;
                        $display("FAIL %s: got %b at edge %0d, required %b at edge %0d",
                                 e.tag, vec, cyc, e.vec, e.edge_n);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset         = 1'b1;
        ctl.enable    = 1'b0;
        ctl.hs_req    = 1'b0;
        ctl.data_done = 1'b0;
        push(3, V_STOP, "reset_state");

        at_edge(4);
        reset      = 1'b0;
        ctl.enable = 1'b1;

        // A: single request, then teardown by data_done (or enable in continuous mode)
        push(10, V_RQST, "A_rqst");
        push(12, V_BRDG, "A_bridge");
        push(14, V_ZERO, "A_zero");
        push(26, V_PRE,  "A_pre");
        push(28, V_CLK,  "A_clk");
`ifdef CSI_TX_CLK_CONTINUOUS_EN
        push(45, V_TRAIL, "A_cont_trail");
        push(48, V_EXIT,  "A_cont_exit");
        push(52, V_STOP,  "A_cont_stop");
`else
        push(40, V_POST,  "A_post");
        push(48, V_TRAIL, "A_trail");
        push(51, V_EXIT,  "A_exit");
        push(55, V_STOP,  "A_stop");
`endif
        at_edge(10); ctl.hs_req    = 1'b1;
        at_edge(11); ctl.hs_req    = 1'b0;
        at_edge(40); ctl.data_done = 1'b1;
        at_edge(41); ctl.data_done = 1'b0;
`ifdef CSI_TX_CLK_CONTINUOUS_EN
        at_edge(45); ctl.enable = 1'b0;
        at_edge(53); ctl.enable = 1'b1;
`endif

        // B: enable drops in BRIDGE -> straight back to STOP
        push(60, V_RQST, "B_rqst");
        push(62, V_BRDG, "B_bridge");
        push(63, V_STOP, "B_abort");
        at_edge(60); ctl.hs_req = 1'b1;
        at_edge(61); ctl.hs_req = 1'b0;
        at_edge(63); ctl.enable = 1'b0;
        at_edge(64); ctl.enable = 1'b1;

        // C: enable drops in HS_CLK and stays low through TRAIL/EXIT
        push(70,  V_RQST,  "C_rqst");
        push(72,  V_BRDG,  "C_bridge");
        push(74,  V_ZERO,  "C_zero");
        push(86,  V_PRE,   "C_pre");
        push(88,  V_CLK,   "C_clk");
        push(95,  V_TRAIL, "C_trail");
        push(98,  V_EXIT,  "C_exit");
        push(102, V_STOP,  "C_stop");
        at_edge(70);  ctl.hs_req = 1'b1;
        at_edge(71);  ctl.hs_req = 1'b0;
        at_edge(95);  ctl.enable = 1'b0;
        at_edge(100); ctl.enable = 1'b1;

        push(110, V_RQST, "D_rqst");
        push(112, V_BRDG, "D_bridge");
        push(114, V_ZERO, "D_zero");
        push(126, V_PRE,  "D_pre");
        push(128, V_CLK,  "D_clk");
`ifdef CSI_TX_CLK_CONTINUOUS_EN
        // D: data_done ignored, hs_req dropped, reset leaves HS_CLK
        push(140, V_STOP, "D_cont_reset");
        at_edge(110); ctl.hs_req    = 1'b1;
        at_edge(130); ctl.data_done = 1'b1;
        at_edge(131); ctl.data_done = 1'b0; ctl.hs_req = 1'b0;
        at_edge(140); reset = 1'b1;
        at_edge(141); reset = 1'b0;
`else
        // D: hs_req held -> back-to-back sequences with one STOP cycle; reset in HS_POST
        push(130, V_POST,  "D_post");
        push(138, V_TRAIL, "D_trail");
        push(141, V_EXIT,  "D_exit");
        push(145, V_STOP,  "D_stop_gap");
        push(146, V_RQST,  "D2_rqst");
        push(148, V_BRDG,  "D2_bridge");
        push(150, V_ZERO,  "D2_zero");
        push(162, V_PRE,   "D2_pre");
        push(164, V_CLK,   "D2_clk");
        push(170, V_POST,  "D2_post");
        push(172, V_STOP,  "E_reset_in_post");
        at_edge(110); ctl.hs_req    = 1'b1;
        at_edge(130); ctl.data_done = 1'b1;
        at_edge(131); ctl.data_done = 1'b0;
        at_edge(132); ctl.enable    = 1'b0;
        at_edge(133); ctl.enable    = 1'b1;
        at_edge(147); ctl.hs_req    = 1'b0;
        at_edge(170); ctl.data_done = 1'b1;
        at_edge(171); ctl.data_done = 1'b0;
        at_edge(172); reset         = 1'b1;
        at_edge(173); reset         = 1'b0;
`endif

        at_edge(190);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0 (next %s at edge %0d)",
                     exp_q.size(), exp_q[0].tag, exp_q[0].edge_n);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
